add_pipe_chunked: RTL and testbench
===================================

// Module: add_pipe_chunked
// PURPOSE
//  - Parametrised pipelined adder/subtractor; successor to the combinational carry-chain adder.
//  - Adds carry-in, carry-out, subtract mode, signed-overflow/zero flags and a valid/ready handshake.
//  - Splits DATA_LEN into STAGES equal chunks, one chunk per cycle, so long adds meet timing.
//  - Used in the NPC EXU/multi-cycle datapath and in wide-counter helpers.
// PARAMETERS
//  - DATA_LEN  32  operand/result width; must be a multiple of STAGES (elaboration $error otherwise)
//  - STAGES     4  pipeline depth = number of chunks; 1 gives a single registered add
// PORTS
//  - clk        in   1         clock, all state on rising edge
//  - rst        in   1         synchronous reset, active-high
//  - in_valid   in   1         operand beat valid
//  - in_ready   out  1         block can accept a beat this cycle
//  - op_sub     in   1         1: A-B (B inverted, carry forced 1, Cin ignored); 0: A+B+Cin
//  - Cin        in   1         carry-in, add mode only
//  - OP_A       in   DATA_LEN  operand A
//  - OP_B       in   DATA_LEN  operand B
//  - out_valid  out  1         result valid
//  - out_ready  in   1         consumer accepts result
//  - Sum        out  DATA_LEN  result, modulo 2^DATA_LEN
//  - Cout       out  1         carry out of MSB; in sub mode 1 = no borrow (A>=B unsigned)
//  - Ovf        out  1         signed overflow: sign(A)==sign(B') && sign(Sum)!=sign(A), B'=effective B
//  - Zero       out  1         Sum == 0
// BEHAVIOUR
//  - CW = DATA_LEN/STAGES. Stage k (0..STAGES-1) adds chunk k of A and B' plus carry from stage k-1
//    (stage 0 uses Cin or op_sub), registers the chunk sum and carry, forwards higher operand chunks.
//  - Lower chunk sums computed earlier ride along in skew registers; beat exits stage STAGES-1 complete.
//  - Latency: beat accepted in cycle t -> out_valid high in cycle t+STAGES (when no stall).
//  - Throughput: one beat per cycle while out_ready stays high.
//  - Stall: pipeline advances when adv = !out_valid || out_ready; in_ready = adv (combinational).
//  - Accept occurs on in_valid && in_ready; when adv=0 every stage register, incl. valid bits, holds.
//  - Bubbles: per-stage valid bit; an empty stage is filled even when later stages are full only if adv=1
//    (global stall, no bubble collapsing).
//  - Outputs are registers (Sum, Cout, Ovf, Zero, out_valid); they remain stable while out_valid && !out_ready.
//  - Zero and Ovf computed in final stage from the full assembled sum and registered operand sign bits.
//  - Reset: all stage valid bits 0, out_valid=0, Sum=0, Cout=0, Ovf=0, Zero=0; in_ready=1 from the first
//    cycle after reset. Reset mid-operation discards every in-flight beat; no partial result emerges.
//  - Simultaneous final-stage output and new input with out_ready=1: both happen in the same cycle.
//  - Wrap-around: Sum is modulo 2^DATA_LEN; carry beyond MSB appears only on Cout.
//  - STAGES=1: behaves as one registered full adder with the same handshake.
// CONFIGURATION
//  - ADD_PIPE_SAT_EN defined: extra input sat (1 bit, travels with the beat). When sat=1 and Ovf=1,
//    Sum clamps to signed max (0x7FFF_FFFF) if sign(A)=0, else signed min (0x8000_0000); Ovf still
//    reports 1, Zero reflects the clamped value. Clamp sits in the final stage, latency unchanged.
//  - Undefined: no sat port, no clamp logic; Sum always modulo result.
// TESTING (DATA_LEN=32, STAGES=4)
//  - Add with carry: A=0xFFFF_FFFF, B=0x0000_0001, Cin=0 -> 4 cycles later Sum=0, Cout=1, Zero=1, Ovf=0.
//  - Chunk carry ripple: A=0x00FF_FFFF, B=1, Cin=1 -> Sum=0x0100_0001, Cout=0; confirms carry across 3 chunks.
//  - Subtract/overflow: op_sub=1, A=0x8000_0000, B=1 -> Sum=0x7FFF_FFFF, Cout=1, Ovf=1;
//    with ADD_PIPE_SAT_EN and sat=1 -> Sum=0x8000_0000, Ovf=1.
//  - Back-to-back: 8 random beats on consecutive cycles, out_ready=1 -> 8 results on consecutive cycles
//    matching a reference model, first at cycle t+4.
//  - Backpressure: out_ready=0 for 5 cycles with 6 beats offered -> in_ready drops once out_valid=1,
//    outputs stable, no beat lost or duplicated after out_ready returns.
//  - Reset mid-flight: 3 beats in pipe, rst pulsed 1 cycle -> out_valid=0, no stale result; next beat
//    emerges 4 cycles after accept.

Source files
------------

// File: rtl/add_pipe_chunked_if.sv
// Operand/result handshake bundle for add_pipe_chunked.
// Optional feature macro: ADD_PIPE_SAT_EN adds the per-beat 'sat' request line.
interface add_pipe_chunked_if #(
    parameter int DATA_LEN = 32
);
    logic                in_valid;
    logic                in_ready;
    logic                op_sub;
    logic                Cin;
    logic [DATA_LEN-1:0] OP_A;
    logic [DATA_LEN-1:0] OP_B;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] Sum;
    logic                Cout;
    logic                Ovf;
    logic                Zero;
`ifdef ADD_PIPE_SAT_EN
    logic                sat;
`endif

    // Producer/consumer side: supplies operands and accepts results.
    modport master (
        output in_valid, op_sub, Cin, OP_A, OP_B, out_ready,
        input  in_ready, out_valid, Sum, Cout, Ovf, Zero
`ifdef ADD_PIPE_SAT_EN
        , output sat
`endif
    );

    // Adder side.
    modport slave (
        input  in_valid, op_sub, Cin, OP_A, OP_B, out_ready,
        output in_ready, out_valid, Sum, Cout, Ovf, Zero
`ifdef ADD_PIPE_SAT_EN
        , input sat
`endif
    );
endinterface

// File: rtl/add_pipe_chunked.sv
// Pipelined adder/subtractor: DATA_LEN is split into STAGES chunks, one chunk
// added per cycle with the carry registered between stages. Lower chunk sums
// ride along with the beat until the last stage assembles the full result and
// derives the Zero/Ovf flags. Global stall: every stage advances together.
// Optional feature macro: ADD_PIPE_SAT_EN enables signed saturation on overflow
// when the beat carries sat=1.
module add_pipe_chunked #(
    parameter int DATA_LEN = 32,
    parameter int STAGES   = 4
) (
    input  logic               clk,
    input  logic               rst,
    add_pipe_chunked_if.slave  bus
);
    localparam int CW = DATA_LEN / STAGES;
    // Number of inter-stage registers; kept at least 1 so STAGES=1 still elaborates.
    localparam int NR = (STAGES > 1) ? STAGES - 1 : 1;

    if ((STAGES < 1) || (DATA_LEN % STAGES != 0)) begin : g_bad_cfg
        $error("add_pipe_chunked: DATA_LEN must be a positive multiple of STAGES");
    end

    // Inputs seen by each stage: stage 0 looks at the bus, stage k at register k-1.
    logic [STAGES-1:0][DATA_LEN-1:0] stg_a;
    logic [STAGES-1:0][DATA_LEN-1:0] stg_b;     // effective B (inverted when subtracting)
    logic [STAGES-1:0][DATA_LEN-1:0] stg_s;     // lower chunks already summed
    logic [STAGES-1:0]               stg_c;
    logic [STAGES-1:0]               stg_v;
    logic [STAGES-1:0][CW:0]         chunk_res; // {carry, chunk sum} of each stage
    logic [STAGES-1:0][DATA_LEN-1:0] sum_next;  // partial sum including this stage's chunk

    // Inter-stage registers.
    logic [NR-1:0][DATA_LEN-1:0] a_q, a_d;
    logic [NR-1:0][DATA_LEN-1:0] b_q, b_d;
    logic [NR-1:0][DATA_LEN-1:0] s_q, s_d;
    logic [NR-1:0]               c_q, c_d;
    logic [NR-1:0]               v_q, v_d;

    // Output registers.
    logic                out_valid_q, out_valid_d;
    logic [DATA_LEN-1:0] sum_q, sum_d;
    logic                cout_q, cout_d;
    logic                ovf_q, ovf_d;
    logic                zero_q, zero_d;

`ifdef ADD_PIPE_SAT_EN
    logic [STAGES-1:0] stg_sat;
    logic [NR-1:0]     sat_q, sat_d;
`endif

    // Whole pipeline moves only when the output slot is free or being drained.
    logic adv;
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    assign bus.out_valid = out_valid_q;
    assign bus.Sum       = sum_q;
    assign bus.Cout      = cout_q;
    assign bus.Ovf       = ovf_q;
    assign bus.Zero      = zero_q;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign stg_a[gi] = bus.OP_A;
            assign stg_b[gi] = bus.op_sub ? ~bus.OP_B : bus.OP_B;
            assign stg_s[gi] = '0;
            // Subtraction is A + ~B + 1, so the carry-in is forced and Cin ignored.
            assign stg_c[gi] = bus.op_sub | bus.Cin;
            assign stg_v[gi] = bus.in_valid;
`ifdef ADD_PIPE_SAT_EN
            assign stg_sat[gi] = bus.sat;
`endif
        end else begin : g_body
            assign stg_a[gi] = a_q[gi-1];
            assign stg_b[gi] = b_q[gi-1];
            assign stg_s[gi] = s_q[gi-1];
            assign stg_c[gi] = c_q[gi-1];
            assign stg_v[gi] = v_q[gi-1];
`ifdef ADD_PIPE_SAT_EN
            assign stg_sat[gi] = sat_q[gi-1];
`endif
        end

        // One CW-bit slice of the carry chain per stage.
        assign chunk_res[gi] = {1'b0, stg_a[gi][gi*CW +: CW]}
                             + {1'b0, stg_b[gi][gi*CW +: CW]}
                             + (CW+1)'(stg_c[gi]);
        // Chunks above gi are still zero in stg_s, so OR-ing the slice in is enough.
        assign sum_next[gi] = stg_s[gi] | (DATA_LEN'(chunk_res[gi][CW-1:0]) << (gi*CW));
    end

    // Final-stage flags from the assembled sum and the operand sign bits.
    logic [DATA_LEN-1:0] fin_raw;
    logic                fin_a_sign;
    logic                fin_b_sign;
    logic                fin_ovf;
    logic [DATA_LEN-1:0] fin_sum;

    assign fin_raw    = sum_next[STAGES-1];
    assign fin_a_sign = stg_a[STAGES-1][DATA_LEN-1];
    assign fin_b_sign = stg_b[STAGES-1][DATA_LEN-1];
    assign fin_ovf    = (fin_a_sign == fin_b_sign) && (fin_raw[DATA_LEN-1] != fin_a_sign);

    // Result seen by the output register, optionally clamped to the signed range.
    always_comb begin
        fin_sum = fin_raw;
`ifdef ADD_PIPE_SAT_EN
        if (stg_sat[STAGES-1] && fin_ovf) begin
            fin_sum = fin_a_sign ? {1'b1, {(DATA_LEN-1){1'b0}}}
                                 : {1'b0, {(DATA_LEN-1){1'b1}}};
        end
`endif
    end

    // Next state: every register holds unless the pipeline advances.
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        s_d         = s_q;
        c_d         = c_q;
        v_d         = v_q;
`ifdef ADD_PIPE_SAT_EN
        sat_d       = sat_q;
`endif
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (adv) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                a_d[k] = stg_a[k];
                b_d[k] = stg_b[k];
                s_d[k] = sum_next[k];
                c_d[k] = chunk_res[k][CW];
                v_d[k] = stg_v[k];
`ifdef ADD_PIPE_SAT_EN
                sat_d[k] = stg_sat[k];
`endif
            end
            out_valid_d = stg_v[STAGES-1];
            // Bubbles leave the last result in place rather than loading junk.
            if (stg_v[STAGES-1]) begin
                sum_d  = fin_sum;
                cout_d = chunk_res[STAGES-1][CW];
                ovf_d  = fin_ovf;
                zero_d = (fin_sum == '0);
            end
        end
    end

    // State registers; reset clears every valid bit so in-flight beats vanish.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            v_q         <= v_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
        a_q <= a_d;
        b_q <= b_d;
        s_q <= s_d;
        c_q <= c_d;
`ifdef ADD_PIPE_SAT_EN
        sat_q <= sat_d;
`endif
    end
endmodule

// File: tb/tb_add_pipe_chunked.sv
// Self-checking bench for add_pipe_chunked (DATA_LEN=32, STAGES=4).
// Honours ADD_PIPE_SAT_EN when the bundle is built with it.
module tb_add_pipe_chunked;
    localparam int DL = 32;
    localparam int ST = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    add_pipe_chunked_if #(.DATA_LEN(DL)) bus();

    add_pipe_chunked #(.DATA_LEN(DL), .STAGES(ST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc_cyc;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          sub;
        bit          cin;
        bit          sat;
        logic [31:0] sum;
        bit          cout;
        bit          ovf;
        bit          zero;
    } vec_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        accepted;
    logic        fired;
    logic [34:0] obs;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: wide unsigned arithmetic for Sum/Cout, true signed range for Ovf.
    function automatic exp_t model(bit sub, bit cin, logic [31:0] a, logic [31:0] b,
                                   bit sat_i, int acc);
        exp_t        e;
        logic [32:0] u;
        longint      sa;
        longint      sb;
        longint      r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            u      = {1'b0, a} - {1'b0, b};
            e.cout = (a >= b);
            r      = sa - sb;
        end else begin
            u      = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            e.cout = u[32];
            r      = sa + sb + longint'(cin);
        end
        e.sum = u[31:0];
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        if (sat_i && e.ovf) e.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        e.zero    = (e.sum == 32'd0);
        e.acc_cyc = acc;
        return e;
    endfunction

    // One clock of stimulus; samples handshake and outputs mid-cycle, pushes accepted beats.
    task automatic drive(input bit v, input bit sub, input bit cin, input logic [31:0] a,
                         input logic [31:0] b, input bit sat_i, input bit ordy);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.op_sub    = sub;
        bus.Cin       = cin;
        bus.OP_A      = a;
        bus.OP_B      = b;
        bus.out_ready = ordy;
`ifdef ADD_PIPE_SAT_EN
        bus.sat       = sat_i;
`endif
        @(negedge clk);
        accepted = v && bus.in_ready;
        fired    = bus.out_valid && ordy;
        obs      = {bus.Sum, bus.Cout, bus.Ovf, bus.Zero};
        if (accepted) exp_q.push_back(model(sub, cin, a, b, sat_i, cyc));
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op_sub    = 1'b0;
        bus.Cin       = 1'b0;
        bus.OP_A      = '0;
        bus.OP_B      = '0;
        bus.out_ready = 1'b0;
`ifdef ADD_PIPE_SAT_EN
        bus.sat       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks += 6;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.Sum !== 32'd0)      begin n_fail++; $display("FAIL reset_sum: got %h expected 0", bus.Sum); end
        if (bus.Cout !== 1'b0)      begin n_fail++; $display("FAIL reset_cout: got %b expected 0", bus.Cout); end
        if (bus.Ovf !== 1'b0)       begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", bus.Ovf); end
        if (bus.Zero !== 1'b0)      begin n_fail++; $display("FAIL reset_zero: got %b expected 0", bus.Zero); end
        if (bus.in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        $display("reset: out_valid=%b in_ready=%b Sum=%h", bus.out_valid, bus.in_ready, bus.Sum);
    endtask

    task automatic test_directed();
        vec_t vecs[$];
        int   t_acc;
        exp_t e;
        vecs.push_back('{a:32'hFFFF_FFFF, b:32'h0000_0001, sub:0, cin:0, sat:0, sum:32'h0000_0000, cout:1, ovf:0, zero:1});
        vecs.push_back('{a:32'h00FF_FFFF, b:32'h0000_0001, sub:0, cin:1, sat:0, sum:32'h0100_0001, cout:0, ovf:0, zero:0});
        vecs.push_back('{a:32'h8000_0000, b:32'h0000_0001, sub:1, cin:0, sat:0, sum:32'h7FFF_FFFF, cout:1, ovf:1, zero:0});
        vecs.push_back('{a:32'h0000_0005, b:32'h0000_0005, sub:1, cin:1, sat:0, sum:32'h0000_0000, cout:1, ovf:0, zero:1});
        vecs.push_back('{a:32'h0000_0001, b:32'h0000_0002, sub:1, cin:0, sat:0, sum:32'hFFFF_FFFF, cout:0, ovf:0, zero:0});
        vecs.push_back('{a:32'h7FFF_FFFF, b:32'h0000_0000, sub:0, cin:1, sat:0, sum:32'h8000_0000, cout:0, ovf:1, zero:0});
`ifdef ADD_PIPE_SAT_EN
        vecs.push_back('{a:32'h8000_0000, b:32'h0000_0001, sub:1, cin:0, sat:1, sum:32'h8000_0000, cout:1, ovf:1, zero:0});
        vecs.push_back('{a:32'h7FFF_FFFF, b:32'h0000_0001, sub:0, cin:0, sat:1, sum:32'h7FFF_FFFF, cout:0, ovf:1, zero:0});
`endif
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b, vecs[i].sat, 1'b1);
            t_acc = cyc;
            n_checks++;
            if (accepted !== 1'b1) begin n_fail++; $display("FAIL directed_accept[%0d]: got %b expected 1", i, accepted); end
            for (int w = 0; w < 12; w++) begin
                drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
                if (fired) break;
            end
            n_checks++;
            if (!fired) begin
                n_fail++;
                $display("FAIL directed_timeout[%0d]: got no out_valid expected result within 12 cycles", i);
            end else begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                if (obs !== {vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero}) begin
                    n_fail++;
                    $display("FAIL directed_result[%0d]: got Sum=%h C=%b V=%b Z=%b expected Sum=%h C=%b V=%b Z=%b",
                             i, obs[34:3], obs[2], obs[1], obs[0],
                             vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero);
                end
                n_checks++;
                if (cyc - t_acc != ST) begin
                    n_fail++;
                    $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, cyc - t_acc, ST);
                end
                $display("directed[%0d]: A=%h B=%h sub=%b -> Sum=%h C=%b V=%b Z=%b lat=%0d",
                         i, vecs[i].a, vecs[i].b, vecs[i].sub, obs[34:3], obs[2], obs[1], obs[0], cyc - t_acc);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ra[8];
        logic [31:0] rb[8];
        bit          rs[8];
        bit          rc[8];
        bit          rt[8];
        int          got = 0;
        int          last_fire = 0;
        exp_t        e;
        for (int i = 0; i < 8; i++) begin
            ra[i] = $urandom();
            rb[i] = $urandom();
            rs[i] = 1'($urandom_range(0, 1));
            rc[i] = 1'($urandom_range(0, 1));
`ifdef ADD_PIPE_SAT_EN
            rt[i] = 1'($urandom_range(0, 1));
`else
            rt[i] = 1'b0;
`endif
        end
        for (int i = 0; i < 30 && got < 8; i++) begin
            if (i < 8) drive(1'b1, rs[i], rc[i], ra[i], rb[i], rt[i], 1'b1);
            else       drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            if (i < 8) begin
                n_checks++;
                if (accepted !== 1'b1) begin n_fail++; $display("FAIL b2b_accept[%0d]: got %b expected 1", i, accepted); end
            end
            if (fired) begin
                n_checks += 2;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: got Sum=%h expected no result", obs[34:3]);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== {e.sum, e.cout, e.ovf, e.zero}) begin
                        n_fail++;
                        $display("FAIL b2b_result[%0d]: got %h/%b%b%b expected %h/%b%b%b",
                                 got, obs[34:3], obs[2], obs[1], obs[0], e.sum, e.cout, e.ovf, e.zero);
                    end
                    if (cyc - e.acc_cyc != ST) begin
                        n_fail++;
                        $display("FAIL b2b_latency[%0d]: got %0d expected %0d", got, cyc - e.acc_cyc, ST);
                    end
                end
                if (got > 0) begin
                    n_checks++;
                    if (cyc != last_fire + 1) begin
                        n_fail++;
                        $display("FAIL b2b_gap[%0d]: got output at cycle %0d expected %0d", got, cyc, last_fire + 1);
                    end
                end
                $display("b2b[%0d]: Sum=%h C=%b V=%b Z=%b", got, obs[34:3], obs[2], obs[1], obs[0]);
                last_fire = cyc;
                got++;
            end
        end
        n_checks++;
        if (got != 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", got); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ra[6];
        logic [31:0] rb[6];
        int          sent = 0;
        int          got  = 0;
        bit          ordy;
        exp_t        e;
        for (int i = 0; i < 6; i++) begin
            ra[i] = $urandom();
            rb[i] = $urandom();
        end
        for (int i = 0; i < 60 && got < 6; i++) begin
            ordy = (i >= 5);
            if (sent < 6) drive(1'b1, i[0], i[1], ra[sent], rb[sent], 1'b0, ordy);
            else          drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, ordy);
            if (accepted) sent++;
            if (bus.out_valid && !ordy) begin
                n_checks += 2;
                if (bus.in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_in_ready: got %b expected 0 at cycle %0d", bus.in_ready, cyc);
                end
                if (exp_q.size() == 0 || obs !== {exp_q[0].sum, exp_q[0].cout, exp_q[0].ovf, exp_q[0].zero}) begin
                    n_fail++;
                    $display("FAIL bp_hold: got Sum=%h expected stalled head result (queue %0d)", obs[34:3], exp_q.size());
                end
            end
            if (fired) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra: got Sum=%h expected no result", obs[34:3]);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== {e.sum, e.cout, e.ovf, e.zero}) begin
                        n_fail++;
                        $display("FAIL bp_result[%0d]: got %h expected %h", got, obs[34:3], e.sum);
                    end
                end
                $display("bp[%0d]: Sum=%h C=%b V=%b Z=%b", got, obs[34:3], obs[2], obs[1], obs[0]);
                got++;
            end
        end
        n_checks += 2;
        if (got != 6)  begin n_fail++; $display("FAIL bp_count: got %0d expected 6", got); end
        if (sent != 6) begin n_fail++; $display("FAIL bp_sent: got %0d expected 6", sent); end
    endtask

    task automatic test_reset_midflight();
        int   t_acc;
        exp_t e;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 32'h1000 + i, 32'h1, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_stale[%0d]: got out_valid=%b Sum=%h expected out_valid 0", i, bus.out_valid, obs[34:3]);
            end
        end
        drive(1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        t_acc = cyc;
        for (int w = 0; w < 12; w++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            if (fired) break;
        end
        n_checks += 2;
        if (!fired || exp_q.size() == 0) begin
            n_fail += 2;
            $display("FAIL rstmid_timeout: got no result expected one within 12 cycles");
        end else begin
            e = exp_q.pop_front();
            if (obs !== {e.sum, e.cout, e.ovf, e.zero} || obs[34:3] !== 32'h2345_678A) begin
                n_fail++;
                $display("FAIL rstmid_result: got %h expected %h", obs[34:3], 32'h2345_678A);
            end
            if (cyc - t_acc != ST) begin
                n_fail++;
                $display("FAIL rstmid_latency: got %0d expected %0d", cyc - t_acc, ST);
            end
            $display("rstmid: Sum=%h lat=%0d", obs[34:3], cyc - t_acc);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got no completion expected finish before 50000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
